aplic_msi_writer: RTL and testbench

Downstream delivery stage of the APLIC in MSI mode. Accepts interrupt-forwarding requests (privilege level, hart index, guest index, EIID) from the per-domain delivery logic and buffers them in a small FIFO. Computes each MSI target address from the live `mmsiaddrcfg`/`smsiaddrcfg` register values and issues one 32-bit bus write per request. Writes go out one at a time, and the block waits for each write response before starting the next.

---
 rtl/aplic_msi_writer.sv | 156 +++++++++++++++
 tb/tb_aplic_msi_writer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aplic_msi_writer.sv
// APLIC MSI-mode delivery stage: queues forwarded interrupts and turns each
// into one 32-bit MSI write, waiting for the response before the next one.

typedef enum logic {PRIV_M = 1'b0, PRIV_S = 1'b1} privLevelT;

typedef struct packed {
    logic [43:0] basePPN;
    logic [4:0]  HHXS;
    logic [2:0]  LHXS;
    logic [2:0]  HHXW;
    logic [3:0]  LHXW;
} mmsiaddrcfgT;

typedef struct packed {
    logic [43:0] basePPN;
    logic [2:0]  LHXS;
} smsiaddrcfgT;

module aplic_msi_writer #(
    parameter int QDEPTH     = 4,
    parameter int EIIDW      = 11,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic             reqPriv,
    input  logic [13:0]      reqHartIndex,
    input  logic [5:0]       reqGuestIndex,
    input  logic [EIIDW-1:0] reqEIID,
    input  mmsiaddrcfgT      mcfg,
    input  smsiaddrcfgT      scfg,
    output logic             wrValid,
    input  logic             wrReady,
    output logic [55:0]      wrAddr,
    output logic [31:0]      wrData,
    input  logic             respValid,
    input  logic             respErr,
    output logic [7:0]       errCount,
    output logic             busy
);
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        privLevelT        priv;
        logic [13:0]      hart;
        logic [5:0]       guest;
        logic [EIIDW-1:0] eiid;
    } entry_t;

    entry_t        mem [QDEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    state_t        state;

    function automatic logic [55:0] msi_addr(input entry_t e, input mmsiaddrcfgT m,
                                             input smsiaddrcfgT s);
        logic [43:0] hart_w;
        logic [43:0] h;
        logic [43:0] g;
        logic [43:0] ppn;
        hart_w = 44'(e.hart);
        h      = hart_w & ((44'd1 << m.LHXW) - 44'd1);
        g      = (hart_w >> m.LHXW) & ((44'd1 << m.HHXW) - 44'd1);
        // Group-index placement always follows the machine-level HHXS.
        ppn    = g << (6'd12 + 6'(m.HHXS));
        if (e.priv == PRIV_S)
            ppn = ppn | s.basePPN | (h << s.LHXS) | 44'(e.guest);
        else
            ppn = ppn | m.basePPN | (h << m.LHXS);
        return {ppn, 12'h000};
    endfunction

    function automatic logic [31:0] msi_data(input logic [EIIDW-1:0] eiid);
        logic [31:0] d;
        d = 32'(eiid);
        if (BIG_ENDIAN)
            d = {d[7:0], d[15:8], d[23:16], d[31:24]};
        return d;
    endfunction

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign reqReady = !full;
    // EIID 0 is a null interrupt: handshaken but never queued.
    assign push     = reqValid && !full && (reqEIID != '0);
    assign pop      = (state == IDLE) && !empty;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign busy     = !empty || (state != IDLE);

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{priv: privLevelT'(reqPriv), hart: reqHartIndex,
                                     guest: reqGuestIndex, eiid: reqEIID};
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            wrValid  <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            errCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        wrAddr  <= msi_addr(head, mcfg, scfg);
                        wrData  <= msi_data(head.eiid);
                        wrValid <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wrReady) begin
                        wrValid <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (respValid) begin
                        state <= IDLE;
                        if (respErr && (errCount != 8'hFF))
                            errCount <= errCount + 8'd1;
                    end
                end
                default: begin
                    wrValid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aplic_msi_writer.sv
// Directed plus randomized bench for aplic_msi_writer against an arithmetic
// reference model of the MSI address/data rules.

module tb_aplic_msi_writer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        nReset;
    logic        reqValid;
    logic        reqReady;
    logic        reqPriv;
    logic [13:0] reqHartIndex;
    logic [5:0]  reqGuestIndex;
    logic [10:0] reqEIID;
    logic [43:0] m_base;
    logic [4:0]  m_hhxs;
    logic [2:0]  m_lhxs;
    logic [2:0]  m_hhxw;
    logic [3:0]  m_lhxw;
    logic [43:0] s_base;
    logic [2:0]  s_lhxs;
    logic        wrValid;
    logic        wrReady;
    logic [55:0] wrAddr;
    logic [31:0] wrData;
    logic        respValid;
    logic        respErr;
    logic [7:0]  errCount;
    logic        busy;

    logic        be_reqReady;
    logic        be_wrValid;
    logic [55:0] be_wrAddr;
    logic [31:0] be_wrData;
    logic [7:0]  be_errCount;
    logic        be_busy;

    int checks = 0;
    int errors = 0;
    int model_err = 0;

    aplic_msi_writer #(.QDEPTH(4), .EIIDW(11), .BIG_ENDIAN(1'b0)) dut (
        .clock(clock), .nReset(nReset),
        .reqValid(reqValid), .reqReady(reqReady), .reqPriv(reqPriv),
        .reqHartIndex(reqHartIndex), .reqGuestIndex(reqGuestIndex), .reqEIID(reqEIID),
        .mcfg({m_base, m_hhxs, m_lhxs, m_hhxw, m_lhxw}), .scfg({s_base, s_lhxs}),
        .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData),
        .respValid(respValid), .respErr(respErr), .errCount(errCount), .busy(busy)
    );

    aplic_msi_writer #(.QDEPTH(4), .EIIDW(11), .BIG_ENDIAN(1'b1)) dut_be (
        .clock(clock), .nReset(nReset),
        .reqValid(reqValid), .reqReady(be_reqReady), .reqPriv(reqPriv),
        .reqHartIndex(reqHartIndex), .reqGuestIndex(reqGuestIndex), .reqEIID(reqEIID),
        .mcfg({m_base, m_hhxs, m_lhxs, m_hhxw, m_lhxw}), .scfg({s_base, s_lhxs}),
        .wrValid(be_wrValid), .wrReady(wrReady), .wrAddr(be_wrAddr), .wrData(be_wrData),
        .respValid(respValid), .respErr(respErr), .errCount(be_errCount), .busy(be_busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: MSI address from the interrupt-file numbering rules.
    function automatic longint unsigned ref_addr(input bit priv, input int unsigned hart,
                                                 input int unsigned guest);
        longint unsigned h;
        longint unsigned g;
        longint unsigned ppn;
        h = hart % (64'd1 << m_lhxw);
        g = (hart >> m_lhxw) % (64'd1 << m_hhxw);
        g = g * (64'd1 << (m_hhxs + 12));
        if (priv)
            ppn = s_base | g | (h * (64'd1 << s_lhxs)) | guest;
        else
            ppn = m_base | g | (h * (64'd1 << m_lhxs));
        return (ppn % (64'd1 << 44)) * 4096;
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] d);
        int unsigned v;
        v = d;
        return ((v % 256) * 32'h0100_0000) + (((v / 256) % 256) * 32'h1_0000) +
               (((v / 65536) % 256) * 32'h100) + (v / 32'h0100_0000);
    endfunction

    task automatic push(input bit priv, input int unsigned hart, input int unsigned guest,
                        input int unsigned eiid);
        reqValid      = 1'b1;
        reqPriv       = priv;
        reqHartIndex  = 14'(hart);
        reqGuestIndex = 6'(guest);
        reqEIID       = 11'(eiid);
        do_check("req_ready", reqReady, 1);
        tick();
        reqValid = 1'b0;
    endtask

    task automatic wait_wr(input int max_cycles);
        int n;
        n = 0;
        while (!wrValid && n < max_cycles) begin
            tick();
            n++;
        end
        do_check("wr_timeout", wrValid, 1);
    endtask

    task automatic complete_write(input string tag, input longint unsigned exp_addr,
                                  input int unsigned eiid, input int ready_delay, input bit err);
        wait_wr(20);
        do_check({tag, "_addr"}, wrAddr, exp_addr);
        do_check({tag, "_data"}, wrData, 64'(eiid));
        do_check({tag, "_data_be"}, be_wrData, bswap(32'(eiid)));
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            do_check({tag, "_hold"}, wrAddr, exp_addr);
        end
        wrReady = 1'b1;
        tick();
        wrReady = 1'b0;
        do_check({tag, "_vld_low"}, wrValid, 0);
        respValid = 1'b1;
        respErr   = err;
        tick();
        respValid = 1'b0;
        respErr   = 1'b0;
        if (err && model_err < 255)
            model_err++;
        do_check({tag, "_errcnt"}, errCount, 64'(model_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint unsigned exp_q[$];
        longint unsigned exp_old;
        longint unsigned exp_new;
        bit          r_priv;
        int unsigned r_hart;
        int unsigned r_guest;
        int unsigned r_eiid;
        bit          r_err;

        nReset = 1'b0; reqValid = 1'b0; reqPriv = 1'b0; reqHartIndex = '0;
        reqGuestIndex = '0; reqEIID = '0; wrReady = 1'b0; respValid = 1'b0; respErr = 1'b0;
        m_base = '0; m_hhxs = '0; m_lhxs = '0; m_hhxw = '0; m_lhxw = '0;
        s_base = '0; s_lhxs = '0;
        repeat (3) tick();
        do_check("rst_wrvalid", wrValid, 0);
        do_check("rst_wraddr", wrAddr, 0);
        do_check("rst_wrdata", wrData, 0);
        do_check("rst_errcount", errCount, 0);
        do_check("rst_busy", busy, 0);
        do_check("rst_reqready", reqReady, 1);
        #3 nReset = 1'b1;
        tick();

        // M-level address and two-cycle latency
        m_base = 44'h80000; m_lhxw = 4'd2; m_hhxw = 3'd1; m_hhxs = 5'd4; m_lhxs = 3'd0;
        push(1'b0, 5, 0, 32'h2A);
        do_check("m_lat_t1", wrValid, 0);
        tick();
        do_check("m_lat_t2", wrValid, 1);
        do_check("m_addr_const", wrAddr, 64'h9000_1000);
        complete_write("m", ref_addr(1'b0, 5, 0), 32'h2A, 0, 1'b0);

        // S-level address, big-endian data
        s_base = 44'h40000; s_lhxs = 3'd1; m_lhxw = 4'd2; m_hhxw = 3'd0;
        push(1'b1, 2, 3, 32'h2A);
        tick();
        do_check("s_addr_const", wrAddr, 64'h4000_7000);
        do_check("s_data_be_const", be_wrData, 64'h2A00_0000);
        complete_write("s", ref_addr(1'b1, 2, 3), 32'h2A, 1, 1'b0);

        // EIID 0 is swallowed
        push(1'b0, 7, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_check("eiid0_busy", busy, 0);
            do_check("eiid0_wrvalid", wrValid, 0);
            tick();
        end

        // Full FIFO under a stalled bus, then in-order drain
        m_base = 44'h80000; m_lhxw = 4'd2; m_hhxw = 3'd1; m_hhxs = 5'd4; m_lhxs = 3'd0;
        wrReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, i + 4, 0, i + 1);
            exp_q.push_back(ref_addr(1'b0, i + 4, 0));
        end
        do_check("full_ready", reqReady, 0);
        do_check("full_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            do_check("stall_addr", wrAddr, exp_q[0]);
            do_check("stall_data", wrData, 1);
            do_check("stall_ready", reqReady, 0);
        end
        wrReady = 1'b1;
        tick();
        wrReady = 1'b0;
        respValid = 1'b1;
        tick();
        respValid = 1'b0;
        do_check("b2b_r1_wrvalid", wrValid, 0);
        do_check("full_ready_r1", reqReady, 0);
        tick();
        do_check("b2b_r2_wrvalid", wrValid, 1);
        do_check("ready_after_pop", reqReady, 1);
        for (int i = 1; i < 5; i++)
            complete_write("fifo", exp_q[i], i + 1, 0, 1'b0);

        // Config change while the write is stalled in ISSUE
        push(1'b0, 1, 0, 7);
        tick();
        exp_old = ref_addr(1'b0, 1, 0);
        do_check("cfg_old_addr", wrAddr, exp_old);
        m_base = 44'hABC00;
        push(1'b0, 1, 0, 8);
        for (int i = 0; i < 2; i++) begin
            tick();
            do_check("cfg_hold_addr", wrAddr, exp_old);
        end
        exp_new = ref_addr(1'b0, 1, 0);
        wrReady = 1'b1;
        tick();
        wrReady = 1'b0;
        respValid = 1'b1;
        tick();
        respValid = 1'b0;
        complete_write("cfg_new", exp_new, 8, 0, 1'b0);

        // Randomized requests and configurations
        for (int it = 0; it < 24; it++) begin
            m_base = 44'({$urandom(), $urandom()});
            s_base = 44'({$urandom(), $urandom()});
            m_lhxw = 4'($urandom_range(0, 4));
            m_hhxw = 3'($urandom_range(0, 3));
            m_hhxs = 5'($urandom_range(0, 24));
            m_lhxs = 3'($urandom_range(0, 3));
            s_lhxs = 3'($urandom_range(0, 3));
            r_priv  = 1'($urandom_range(0, 1));
            r_hart  = $urandom_range(0, 16383);
            r_guest = $urandom_range(0, 63);
            r_eiid  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 2047);
            r_err   = 1'($urandom_range(0, 1));
            push(r_priv, r_hart, r_guest, r_eiid);
            if (r_eiid == 0) begin
                for (int i = 0; i < 3; i++) begin
                    do_check("rand_eiid0_busy", busy, 0);
                    do_check("rand_eiid0_wrvalid", wrValid, 0);
                    tick();
                end
            end else begin
                complete_write("rand", ref_addr(r_priv, r_hart, r_guest), r_eiid,
                               $urandom_range(0, 3), r_err);
            end
        end

        // Error counter saturation
        m_base = 44'h80000; m_lhxw = 4'd2; m_hhxw = 3'd1; m_hhxs = 5'd4; m_lhxs = 3'd0;
        for (int i = 0; i < 300; i++) begin
            push(1'b0, 3, 0, 9);
            complete_write("sat", ref_addr(1'b0, 3, 0), 9, 0, 1'b1);
        end
        do_check("sat_final", errCount, 255);

        // Asynchronous reset while a write awaits its response
        push(1'b0, 9, 0, 5);
        wait_wr(5);
        wrReady = 1'b1;
        tick();
        wrReady = 1'b0;
        for (int i = 0; i < 3; i++)
            push(1'b0, 10 + i, 0, 6 + i);
        do_check("rst_pre_busy", busy, 1);
        #3 nReset = 1'b0;
        #1;
        do_check("arst_wrvalid", wrValid, 0);
        do_check("arst_wraddr", wrAddr, 0);
        do_check("arst_wrdata", wrData, 0);
        do_check("arst_errcount", errCount, 0);
        do_check("arst_busy", busy, 0);
        do_check("arst_reqready", reqReady, 1);
        @(posedge clock);
        #3 nReset = 1'b1;
        respValid = 1'b1;
        respErr   = 1'b1;
        tick();
        respValid = 1'b0;
        respErr   = 1'b0;
        do_check("late_resp_errcount", errCount, 0);
        for (int i = 0; i < 8; i++) begin
            do_check("post_rst_wrvalid", wrValid, 0);
            do_check("post_rst_busy", busy, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
